// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer (master) and the datapath/ALU (slave).
// Carries opcode, ALU flag and stall inputs plus every strobe and debug output.
interface multicycle_ctrl_if;
  logic [10:0] Opcode;
  logic        Zero;
  logic        Stall;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc;
  logic        Reg2Loc;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        RegWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        Illegal;
  logic [2:0]  State;
  logic [31:0] Retired;

  modport master (
    input  Opcode, Zero, Stall,
    output ALUCtrl, ALUSrc, Reg2Loc, MemRead, MemWrite, MemToReg,
           RegWrite, IRWrite, PCWrite, PCSrc, Illegal, State, Retired
  );

  modport slave (
    output Opcode, Zero, Stall,
    input  ALUCtrl, ALUSrc, Reg2Loc, MemRead, MemWrite, MemToReg,
           RegWrite, IRWrite, PCWrite, PCSrc, Illegal, State, Retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control sequencer for the LEGv8 multicycle datapath, with retired-instruction counter.
// Optional macro MC_ILLEGAL_TRAP_EN: illegal opcodes park in TRAP instead of retiring as a NOP.
module multicycle_ctrl (
  input  logic              CLK,
  input  logic              ResetN,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_LDUR, CL_STUR, CL_ADD, CL_SUB,
    CL_AND, CL_ORR, CL_MOVZ, CL_CBZ, CL_B
  } class_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  state_t      state, state_next;
  class_t      op_class, decoded_class;
  logic [31:0] retired;
  logic        retire;
  logic [3:0]  class_alu;
  logic        class_imm;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg2loc, mem_read, mem_write, mem_to_reg;
  logic        reg_write, ir_write, pc_write, pc_src, illegal;

  always_comb begin
    decoded_class = CL_ILLEGAL;
    casez (bus.Opcode)
      11'b11111000010: decoded_class = CL_LDUR;
      11'b11111000000: decoded_class = CL_STUR;
      11'b10001011000: decoded_class = CL_ADD;
      11'b11001011000: decoded_class = CL_SUB;
      11'b10001010000: decoded_class = CL_AND;
      11'b10101010000: decoded_class = CL_ORR;
      11'b110100101??: decoded_class = CL_MOVZ;
      11'b10110100???: decoded_class = CL_CBZ;
      11'b000101?????: decoded_class = CL_B;
      default:         decoded_class = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    class_alu = ALU_ADD;
    case (op_class)
      CL_SUB:         class_alu = ALU_SUB;
      CL_AND:         class_alu = ALU_AND;
      CL_ORR:         class_alu = ALU_OR;
      CL_MOVZ, CL_CBZ: class_alu = ALU_PASSB;
      default:        class_alu = ALU_ADD;
    endcase
    class_imm = (op_class == CL_LDUR) || (op_class == CL_STUR) || (op_class == CL_MOVZ);
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (decoded_class == CL_ILLEGAL) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_next = TRAP;
`else
          state_next = FETCH;
`endif
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (op_class)
          CL_LDUR, CL_STUR: state_next = MEM;
          CL_B, CL_CBZ:     state_next = FETCH;
          default:          state_next = WB;
        endcase
      end
      MEM:     state_next = (op_class == CL_LDUR) ? WB : FETCH;
      WB:      state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
    // Only real instructions retire; the illegal-opcode NOP leaves from DECODE.
    retire = (state_next == FETCH) && ((state == EXEC) || (state == MEM) || (state == WB));
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state    <= FETCH;
      op_class <= CL_ILLEGAL;
      retired  <= '0;
    end else if (!bus.Stall) begin
      state <= state_next;
      if (state == DECODE) op_class <= decoded_class;
      if (retire) retired <= retired + 32'd1;
    end
  end

  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      EXEC: begin
        alu_ctrl = class_alu;
        alu_src  = class_imm;
        reg2loc  = (op_class == CL_STUR) || (op_class == CL_CBZ);
        if (op_class == CL_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (op_class == CL_CBZ) begin
          pc_write = bus.Zero;
          pc_src   = 1'b1;
        end
      end
      MEM: begin
        alu_ctrl  = class_alu;
        alu_src   = class_imm;
        mem_read  = (op_class == CL_LDUR);
        mem_write = (op_class == CL_STUR);
      end
      WB: begin
        alu_ctrl   = class_alu;
        alu_src    = class_imm;
        reg_write  = 1'b1;
        mem_to_reg = (op_class == CL_LDUR);
      end
      TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
      default: ;
    endcase
    // Stall suppresses only the strobes that commit architectural state.
    if (bus.Stall) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
    if (!ResetN) begin
      alu_ctrl   = ALU_ADD;
      alu_src    = 1'b0;
      reg2loc    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.ALUSrc   = alu_src;
  assign bus.Reg2Loc  = reg2loc;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.IRWrite  = ir_write;
  assign bus.PCWrite  = pc_write;
  assign bus.PCSrc    = pc_src;
  assign bus.Illegal  = illegal;
  assign bus.State    = state;
  assign bus.Retired  = retired;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Moore control sequencer for the multicycle datapath; it is the driving end of the ALU interface.
- Decodes the LEGv8 opcode held in the instruction register.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing `ALUCtrl` and datapath strobes, and consumes the ALU `Zero` flag to resolve CBZ.
- Keeps a retired-instruction counter for debug and performance checks.

## Interface
- Clock/reset: one clock; reset is asynchronous and active-low (`CLK`, `ResetN`).
- No parameters; widths fixed by LEGv8.
- `CLK` in 1: rising-edge clock.
- `ResetN` in 1: async active-low reset.
- `Opcode` in 11: IR[31:21], stable from the cycle after FETCH.
- `Zero` in 1: ALU `Zero` flag, sampled in EXEC of CBZ.
- `Stall` in 1: hold request from memory.
- `ALUCtrl` out 4: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
- `ALUSrc` out 1: 1 = immediate on BusB.
- `Reg2Loc` out 1: 1 = read Rt as second register.
- `MemRead` out 1: data memory read strobe.
- `MemWrite` out 1: data memory write strobe.
- `MemToReg` out 1: write-back source is memory.
- `RegWrite` out 1: register file write strobe.
- `IRWrite` out 1: IR load strobe.
- `PCWrite` out 1: PC load strobe.
- `PCSrc` out 1: 0 = PC+4, 1 = branch target.
- `Illegal` out 1: trap indicator (macro-dependent).
- `State` out 3: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- `Retired` out 32: count of completed instructions.

## Operation
- Opcode classes, latched into a class register in DECODE:
  - LDUR 11111000010; STUR 11111000000.
  - ADD 10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000.
  - MOVZ 110100101xx; CBZ 10110100xxx; B 000101xxxxx.
  - Anything else is ILLEGAL.
- FETCH: `IRWrite`=1, `PCWrite`=1, `PCSrc`=0, `ALUCtrl`=ADD. Next DECODE.
- DECODE: no strobes; latch class.
  - ILLEGAL → TRAP (see Configuration).
  - B, CBZ, R-type, MOVZ, LDUR, STUR → EXEC.
- EXEC, `ALUCtrl` by class:
  - ADD/LDUR/STUR → ADD; SUB → SUB; AND → AND; ORR → OR; MOVZ/CBZ → PassB.
  - `ALUSrc`=1 for LDUR/STUR/MOVZ; `Reg2Loc`=1 for STUR/CBZ.
  - B: `PCWrite`=1, `PCSrc`=1 → FETCH.
  - CBZ: `PCWrite`=`Zero`, `PCSrc`=1 → FETCH.
  - LDUR/STUR → MEM; R-type/MOVZ → WB.
- MEM: `ALUCtrl`, `ALUSrc` held from EXEC.
  - LDUR: `MemRead`=1 → WB.
  - STUR: `MemWrite`=1 → FETCH.
- WB: `RegWrite`=1; `MemToReg`=1 only for LDUR; `ALUCtrl`/`ALUSrc` held. Next FETCH.
- Unlisted strobes are 0 in every state.
- `Retired` increments by 1, wrapping modulo 2^32, on every transition into FETCH from EXEC, MEM or WB.
- `Stall`=1:
  - State, class and `Retired` hold.
  - `IRWrite`, `PCWrite`, `RegWrite` and `MemWrite` are forced 0.
  - `ALUCtrl`, `ALUSrc`, `Reg2Loc`, `MemRead`, `MemToReg` and `PCSrc` are unchanged.

## Timing
- Outputs are combinational from the state and class registers (Moore); `PCWrite` in CBZ EXEC additionally depends on `Zero`.
- Cycles per instruction with no stall:
  - B, CBZ: 3.
  - R-type, MOVZ, STUR: 4.
  - LDUR: 5.
- Stall adds one cycle per stalled cycle, in any state.
- Reset:
  - While `ResetN`=0, all strobes and `Illegal` are 0, `ALUCtrl`=0010, `State`=FETCH, class=ILLEGAL, `Retired`=0.
  - The first FETCH strobes occur at the first rising edge after deassertion.
  - Reset mid-instruction aborts it immediately; the aborted instruction is not counted.
- `Zero` is sampled only in EXEC of CBZ; it is ignored in all other states.

## Configuration
- Macro `MC_ILLEGAL_TRAP_EN`.
- Defined:
  - ILLEGAL goes DECODE → TRAP.
  - TRAP asserts `Illegal`=1 with all strobes 0 and stays there until reset.
  - `Retired` is not incremented.
- Undefined:
  - ILLEGAL goes DECODE → FETCH as a NOP, with no strobes and no `Retired` increment.
  - TRAP is unreachable; `Illegal` is tied 0.

## Test plan
- Reset, then ADD (10001011000) with no stall → `State` 0,1,2,4,0; EXEC `ALUCtrl`=0010, `ALUSrc`=0; WB `RegWrite`=1, `MemToReg`=0; `Retired`=1.
- LDUR followed by STUR:
  - LDUR: MEM `MemRead`=1; WB `RegWrite`=1, `MemToReg`=1.
  - STUR: EXEC `Reg2Loc`=1; MEM `MemWrite`=1.
  - Totals: 9 cycles, `Retired`=2.
- CBZ with `Zero`=1, then CBZ with `Zero`=0 → EXEC `ALUCtrl`=0111, `PCSrc`=1; `PCWrite` is 1 then 0; each takes 3 cycles.
- `Stall`=1 for 3 cycles during MEM of STUR → `MemWrite`=0 and `State`=3 held; `MemWrite`=1 in the cycle after release; `Retired` increments once.
- Opcode 0 (ILLEGAL):
  - With the macro: `State`=5, `Illegal`=1, held for 10 cycles, `Retired` unchanged.
  - Without the macro: returns to FETCH after 2 cycles with no strobes.
- `ResetN` pulsed low during LDUR WB → `RegWrite` drops to 0 asynchronously, `State`=0, `Retired`=0.
